rpn_prog_loader: RTL and testbench

//  Write side of the RPN program memory: the calculator core reads instructions by PC; this block fills the memory.
//  In load mode it captures SW[7:0] on each debounced KEY press.

---
 rtl/rpn_prog_loader.sv | 126 ++++++++++++
 tb/tb_rpn_prog_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rpn_prog_loader.sv
// Program-memory write side: debounces KEY, writes SW data to sequential addresses while in load mode.
// Latency: key_n low at edge k -> wr_en at edge k+DEBOUNCE_CYCLES+3; no backpressure (memory always accepts).
module rpn_prog_loader #(
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = 8,
  parameter int DEPTH           = 256,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              key_n,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   prog_len,
  output logic              full,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W:0]  LEN_MAX  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state_q, state_d;
  logic              key_meta_q, key_s_q;
  logic              deb_q, deb_d, deb_prev_q, press_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W:0]   len_q, len_d;

  // Debouncer: the switch data is latched on the same edge the debounced level falls.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    cap_d = cap_q;
    if (key_s_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = key_s_q;
        if (!key_s_q) cap_d = data_in;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_q <= 1'b1;
      key_s_q    <= 1'b1;
      deb_q      <= 1'b1;
      deb_prev_q <= 1'b1;
      cnt_q      <= '0;
      press_q    <= 1'b0;
      cap_q      <= '0;
    end else begin
      key_meta_q <= key_n;
      key_s_q    <= key_meta_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
      press_q    <= deb_prev_q & ~deb_q;
      cap_q      <= cap_d;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_en) state_d = LOAD;
      LOAD:    if (!load_en) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A press pending on the edge load_en drops is still written before leaving LOAD.
  always_comb begin
    busy      = (state_q == LOAD);
    done      = (state_q == DONE);
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    len_d     = len_q;
    if (state_q == IDLE && load_en) len_d = '0;
    if (state_q == LOAD && press_q && len_q < LEN_MAX) begin
      wr_en_d   = 1'b1;
      wr_addr_d = len_q[ADDR_W-1:0];
      wr_data_d = cap_q;
      len_d     = len_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      len_q     <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      len_q     <= len_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign prog_len = len_q;
  assign full     = (len_q == LEN_MAX);

endmodule

// File: tb/tb_rpn_prog_loader.sv
// Directed bench for rpn_prog_loader with DEBOUNCE_CYCLES=4, DEPTH=4.
module tb_rpn_prog_loader;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n    = 1'b0;
  logic       load_en  = 1'b0;
  logic       key_n    = 1'b1;
  logic [7:0] data_in  = 8'h00;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [8:0] prog_len;
  logic       full, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int wq_cyc[$];
  logic [7:0] wq_addr[$];
  logic [7:0] wq_data[$];

  rpn_prog_loader #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(4), .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .load_en(load_en), .key_n(key_n),
    .data_in(data_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .prog_len(prog_len), .full(full), .busy(busy), .done(done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(posedge CLOCK_50) begin
    #1;
    if (wr_en) begin
      wq_cyc.push_back(cyc);
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [7:0] a, input logic [7:0] d);
    if (idx < wq_addr.size()) begin
      check({tag, "_addr"}, 32'(wq_addr[idx]), 32'(a));
      check({tag, "_data"}, 32'(wq_data[idx]), 32'(d));
    end else begin
      check({tag, "_present"}, 32'(wq_addr.size()), 32'(idx + 1));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic press(input logic [7:0] d, input int lo);
    data_in = d;
    key_n   = 1'b0;
    tick(lo);
    key_n   = 1'b1;
    tick(12);
  endtask

  initial begin
    int base, k, d0;

    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("rst_wr_en",   32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_len",     32'(prog_len), 0);
    check("rst_full",    32'(full), 0);
    check("rst_busy",    32'(busy), 0);
    check("rst_done",    32'(done), 0);

    // single write with latency, data changed after capture
    load_en = 1'b1;
    tick(2);
    check("load_busy", 32'(busy), 1);
    base = wq_cyc.size();
    data_in = 8'hA9;
    key_n = 1'b0;
    k = cyc + 1;
    tick(6);
    data_in = 8'h55;
    tick(14);
    key_n = 1'b1;
    tick(12);
    check("single_nwr", 32'(wq_cyc.size() - base), 1);
    if (wq_cyc.size() > base) check("single_lat", 32'(wq_cyc[base] - k), 7);
    check_wr("single", base, 8'h00, 8'hA9);
    check("single_len", 32'(prog_len), 1);

    // bounce rejection then clean press
    base = wq_cyc.size();
    key_n = 1'b0; tick(3);
    key_n = 1'b1; tick(2);
    key_n = 1'b0; tick(3);
    key_n = 1'b1; tick(12);
    check("bounce_nwr", 32'(wq_cyc.size() - base), 0);
    press(8'hC4, 10);
    check("bounce_clean_nwr", 32'(wq_cyc.size() - base), 1);
    check_wr("bounce_clean", base, 8'h01, 8'hC4);
    check("bounce_len", 32'(prog_len), 2);

    // new session, three-word program
    load_en = 1'b0; tick(4);
    load_en = 1'b1; tick(2);
    check("reentry_len", 32'(prog_len), 0);
    base = wq_cyc.size();
    press(8'h01, 10);
    press(8'h02, 10);
    press(8'h2B, 10);
    check("seq_nwr", 32'(wq_cyc.size() - base), 3);
    check_wr("seq0", base,     8'h00, 8'h01);
    check_wr("seq1", base + 1, 8'h01, 8'h02);
    check_wr("seq2", base + 2, 8'h02, 8'h2B);
    d0 = done_cnt;
    load_en = 1'b0;
    tick(4);
    check("seq_done", 32'(done_cnt - d0), 1);
    check("seq_len",  32'(prog_len), 3);
    check("seq_busy", 32'(busy), 0);
    check("seq_full", 32'(full), 0);

    // fill to DEPTH, fifth press ignored
    load_en = 1'b1; tick(2);
    base = wq_cyc.size();
    for (int i = 0; i < 5; i++) press(8'(8'h10 + i), 10);
    check("full_nwr", 32'(wq_cyc.size() - base), 4);
    for (int i = 0; i < 4; i++) check_wr("full_w", base + i, 8'(i), 8'(8'h10 + i));
    check("full_flag", 32'(full), 1);
    check("full_len",  32'(prog_len), 4);
    load_en = 1'b0; tick(3);
    check("full_hold_idle", 32'(full), 1);
    load_en = 1'b1; tick(2);
    check("full_reentry_len",  32'(prog_len), 0);
    check("full_reentry_flag", 32'(full), 0);

    // press while idle
    load_en = 1'b0; tick(3);
    base = wq_cyc.size();
    press(8'hEE, 10);
    check("idle_nwr", 32'(wq_cyc.size() - base), 0);

    // key held across LOAD entry
    base = wq_cyc.size();
    key_n = 1'b0; tick(12);
    load_en = 1'b1; tick(10);
    check("held_nwr", 32'(wq_cyc.size() - base), 0);
    key_n = 1'b1; tick(12);
    press(8'h77, 10);
    check("held_repress_nwr", 32'(wq_cyc.size() - base), 1);
    check_wr("held_repress", base, 8'h00, 8'h77);

    // press event on the edge load_en is seen low
    base = wq_cyc.size();
    d0 = done_cnt;
    data_in = 8'h5C;
    key_n = 1'b0;
    k = cyc + 1;
    tick(7);
    load_en = 1'b0;
    tick(3);
    key_n = 1'b1;
    tick(12);
    check("simul_nwr", 32'(wq_cyc.size() - base), 1);
    if (wq_cyc.size() > base) check("simul_lat", 32'(wq_cyc[base] - k), 7);
    check_wr("simul", base, 8'h01, 8'h5C);
    check("simul_len",  32'(prog_len), 2);
    check("simul_done", 32'(done_cnt - d0), 1);
    check("simul_busy", 32'(busy), 0);

    // asynchronous reset while wr_en is high
    load_en = 1'b1; tick(2);
    data_in = 8'h3C;
    key_n = 1'b0;
    tick(7);
    @(posedge CLOCK_50);
    #1;
    check("midrst_wr_en_pre", 32'(wr_en), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_wr_en",   32'(wr_en), 0);
    check("midrst_wr_addr", 32'(wr_addr), 0);
    check("midrst_wr_data", 32'(wr_data), 0);
    check("midrst_len",     32'(prog_len), 0);
    check("midrst_full",    32'(full), 0);
    check("midrst_busy",    32'(busy), 0);
    check("midrst_done",    32'(done), 0);
    load_en = 1'b0;
    key_n = 1'b1;
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    tick(12);
    check("postrst_busy", 32'(busy), 0);
    check("postrst_len",  32'(prog_len), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
